// File: rtl/integer_dispatch_buffer.sv
// Decoupling FIFO between dispatch and the integer issue queue. Buffered uops
// keep snooping the issue wakeup and the ALU/load result broadcasts.
module integer_dispatch_buffer #(
   parameter int DEPTH          = 2,
   parameter int ROB_ID_WIDTH   = 6,
   parameter int REG_DATA_WIDTH = 32,
   parameter int CTRL_WIDTH     = 16,
   parameter int ENTRY_WIDTH    = CTRL_WIDTH + ROB_ID_WIDTH
                                  + 2 * (2 + ROB_ID_WIDTH + REG_DATA_WIDTH)
) (
   input  logic                      clk,
   input  logic                      rst_aL,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ENTRY_WIDTH-1:0]    in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ENTRY_WIDTH-1:0]    out_data,
   input  logic                      iiq_issue_valid,
   input  logic [ROB_ID_WIDTH-1:0]   iiq_issue_rob_id,
   input  logic                      alu_broadcast_valid,
   input  logic [ROB_ID_WIDTH-1:0]   alu_broadcast_rob_id,
   input  logic [REG_DATA_WIDTH-1:0] alu_broadcast_reg_data,
   input  logic                      ld_broadcast_valid,
   input  logic [ROB_ID_WIDTH-1:0]   ld_broadcast_rob_id,
   input  logic [REG_DATA_WIDTH-1:0] ld_broadcast_reg_data,
   input  logic                      fetch_redirect_valid
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   // Packed iiq_entry_t layout, most significant field first.
   typedef struct packed {
      logic [CTRL_WIDTH-1:0]     ctrl;
      logic [ROB_ID_WIDTH-1:0]   rob_id;
      logic                      src1_valid;
      logic                      src1_ready;
      logic [ROB_ID_WIDTH-1:0]   src1_rob_id;
      logic [REG_DATA_WIDTH-1:0] src1_data;
      logic                      src2_valid;
      logic                      src2_ready;
      logic [ROB_ID_WIDTH-1:0]   src2_rob_id;
      logic [REG_DATA_WIDTH-1:0] src2_data;
   } iiq_entry_t;

   typedef struct packed {
      logic                      ready;
      logic [REG_DATA_WIDTH-1:0] data;
   } src_state_t;

   iiq_entry_t       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   iiq_entry_t       w_snooped [DEPTH];
   iiq_entry_t       w_in_entry;
   iiq_entry_t       w_in_snooped;
   logic             w_enq;
   logic             w_deq;

   // ALU data wins over load data on the same tag; any of the three sets ready.
   function automatic src_state_t snoopSrc(
      input logic                      valid,
      input logic                      ready,
      input logic [ROB_ID_WIDTH-1:0]   tag,
      input logic [REG_DATA_WIDTH-1:0] data
   );
      src_state_t s;
      s.ready = ready;
      s.data  = data;
      if (valid && !ready) begin
         if (alu_broadcast_valid && (alu_broadcast_rob_id == tag)) begin
            s.ready = 1'b1;
            s.data  = alu_broadcast_reg_data;
         end else if (ld_broadcast_valid && (ld_broadcast_rob_id == tag)) begin
            s.ready = 1'b1;
            s.data  = ld_broadcast_reg_data;
         end else if (iiq_issue_valid && (iiq_issue_rob_id == tag)) begin
            s.ready = 1'b1;
         end
      end
      return s;
   endfunction

   function automatic iiq_entry_t snoopEntry(input iiq_entry_t e);
      iiq_entry_t r;
      src_state_t s1;
      src_state_t s2;
      r  = e;
      s1 = snoopSrc(e.src1_valid, e.src1_ready, e.src1_rob_id, e.src1_data);
      s2 = snoopSrc(e.src2_valid, e.src2_ready, e.src2_rob_id, e.src2_data);
      r.src1_ready = s1.ready;
      r.src1_data  = s1.data;
      r.src2_ready = s2.ready;
      r.src2_data  = s2.data;
      return r;
   endfunction

   assign w_in_entry = in_data;
   assign in_ready   = (r_count != FULL_COUNT);
   assign out_valid  = (r_count != '0);
   assign w_enq      = in_valid && in_ready;
   assign w_deq      = out_valid && out_ready;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_snooped[i] = snoopEntry(r_mem[i]);
      end
      w_in_snooped = snoopEntry(w_in_entry);
   end

   assign out_data = out_valid ? w_snooped[r_rd_ptr] : '0;

   // Every stored entry absorbs this cycle's broadcasts; a flush drops any enq/deq.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= w_snooped[i];
         end
         if (fetch_redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_enq) begin
               r_mem[r_wr_ptr] <= w_in_snooped;
               r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_integer_dispatch_buffer.sv
// Directed bench for integer_dispatch_buffer: handshakes, snooping, flush and reset.
module tb_integer_dispatch_buffer;

   localparam int EW = 102;

   logic          clk = 1'b0;
   logic          rst_aL;
   logic          in_valid;
   logic          in_ready;
   logic [EW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [EW-1:0] out_data;
   logic          iiq_issue_valid;
   logic [5:0]    iiq_issue_rob_id;
   logic          alu_broadcast_valid;
   logic [5:0]    alu_broadcast_rob_id;
   logic [31:0]   alu_broadcast_reg_data;
   logic          ld_broadcast_valid;
   logic [5:0]    ld_broadcast_rob_id;
   logic [31:0]   ld_broadcast_reg_data;
   logic          fetch_redirect_valid;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [EW-1:0] entA, entB, entC, entD, entE, entF, entG, entH, entI, entJ, entK, entL, entM;

   always #5 clk = ~clk;

   integer_dispatch_buffer dut (
      .clk                    (clk),
      .rst_aL                 (rst_aL),
      .in_valid               (in_valid),
      .in_ready               (in_ready),
      .in_data                (in_data),
      .out_valid              (out_valid),
      .out_ready              (out_ready),
      .out_data               (out_data),
      .iiq_issue_valid        (iiq_issue_valid),
      .iiq_issue_rob_id       (iiq_issue_rob_id),
      .alu_broadcast_valid    (alu_broadcast_valid),
      .alu_broadcast_rob_id   (alu_broadcast_rob_id),
      .alu_broadcast_reg_data (alu_broadcast_reg_data),
      .ld_broadcast_valid     (ld_broadcast_valid),
      .ld_broadcast_rob_id    (ld_broadcast_rob_id),
      .ld_broadcast_reg_data  (ld_broadcast_reg_data),
      .fetch_redirect_valid   (fetch_redirect_valid)
   );

   // Builds a packed entry: ctrl, rob_id, src1 {valid,ready,tag,data}, src2 {valid,ready,tag,data}.
   function automatic logic [EW-1:0] mk(
      input logic [15:0] ctrl, input logic [5:0] rob,
      input logic s1v, input logic s1r, input logic [5:0] s1t, input logic [31:0] s1d,
      input logic s2v, input logic s2r, input logic [5:0] s2t, input logic [31:0] s2d
   );
      return {ctrl, rob, s1v, s1r, s1t, s1d, s2v, s2r, s2t, s2d};
   endfunction

   task automatic checkOutput(input string tag, input logic [EW-1:0] observed,
                              input logic [EW-1:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic inV, input logic [EW-1:0] inD, input logic outR);
      in_valid  = inV;
      in_data   = inD;
      out_ready = outR;
   endtask

   task automatic clearSnoop();
      iiq_issue_valid        = 1'b0;
      iiq_issue_rob_id       = '0;
      alu_broadcast_valid    = 1'b0;
      alu_broadcast_rob_id   = '0;
      alu_broadcast_reg_data = '0;
      ld_broadcast_valid     = 1'b0;
      ld_broadcast_rob_id    = '0;
      ld_broadcast_reg_data  = '0;
      fetch_redirect_valid   = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      entA = mk(16'hA001, 6'd1,  1'b1, 1'b1, 6'd20, 32'h100, 1'b0, 1'b0, 6'd0,  32'h0);
      entB = mk(16'hB002, 6'd2,  1'b1, 1'b1, 6'd21, 32'h200, 1'b0, 1'b0, 6'd0,  32'h0);
      entC = mk(16'hC003, 6'd3,  1'b0, 1'b0, 6'd0,  32'h0,   1'b1, 1'b1, 6'd22, 32'h300);
      entD = mk(16'h0D00, 6'd4,  1'b1, 1'b0, 6'd5,  32'h0,   1'b1, 1'b1, 6'd12, 32'h22);
      entE = mk(16'h0E00, 6'd6,  1'b1, 1'b1, 6'd3,  32'h33,  1'b1, 1'b0, 6'd7,  32'h0);
      entF = mk(16'h0F00, 6'd8,  1'b1, 1'b0, 6'd9,  32'h0,   1'b1, 1'b1, 6'd9,  32'h11);
      entG = mk(16'h1100, 6'd10, 1'b1, 1'b0, 6'd9,  32'h77,  1'b0, 1'b0, 6'd0,  32'h0);
      entH = mk(16'h1200, 6'd11, 1'b0, 1'b0, 6'd0,  32'h0,   1'b0, 1'b0, 6'd0,  32'h0);
      entI = mk(16'h1300, 6'd12, 1'b0, 1'b0, 6'd0,  32'h0,   1'b0, 1'b0, 6'd0,  32'h0);
      entJ = mk(16'h1400, 6'd13, 1'b0, 1'b0, 6'd0,  32'h0,   1'b0, 1'b0, 6'd0,  32'h0);
      entK = mk(16'h1500, 6'd14, 1'b0, 1'b0, 6'd0,  32'h0,   1'b0, 1'b0, 6'd0,  32'h0);
      entL = mk(16'h1600, 6'd15, 1'b0, 1'b0, 6'd0,  32'h0,   1'b0, 1'b0, 6'd0,  32'h0);
      entM = mk(16'h1700, 6'd16, 1'b1, 1'b1, 6'd30, 32'h99,  1'b0, 1'b0, 6'd0,  32'h0);

      rst_aL = 1'b0;
      clearSnoop();
      applyStimulus(1'b0, '0, 1'b0);
      #12;
      checkBit("reset_in_ready", in_ready, 1'b1);
      checkBit("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_out_data", out_data, '0);
      @(negedge clk);
      rst_aL = 1'b1;
      nextCycle();

      // Fill with rob 1,2; rob 3 refused while full.
      applyStimulus(1'b1, entA, 1'b0);
      #1;
      checkBit("enqA_in_ready", in_ready, 1'b1);
      checkBit("enqA_no_bypass", out_valid, 1'b0);
      nextCycle();
      applyStimulus(1'b1, entB, 1'b0);
      #1;
      checkBit("enqB_in_ready", in_ready, 1'b1);
      checkBit("enqB_out_valid", out_valid, 1'b1);
      checkOutput("enqB_head", out_data, entA);
      nextCycle();
      applyStimulus(1'b1, entC, 1'b0);
      #1;
      checkBit("full_in_ready", in_ready, 1'b0);
      checkOutput("full_head", out_data, entA);
      nextCycle();

      // Drain while rob 3 is offered: it enters once space opens, order stays 2,3.
      applyStimulus(1'b1, entC, 1'b1);
      #1;
      checkBit("drain_in_ready", in_ready, 1'b0);
      checkOutput("drain_headA", out_data, entA);
      nextCycle();
      applyStimulus(1'b1, entC, 1'b0);
      #1;
      checkBit("one_left_in_ready", in_ready, 1'b1);
      checkOutput("one_left_headB", out_data, entB);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b1);
      #1;
      checkBit("refill_in_ready", in_ready, 1'b0);
      checkOutput("order_headB", out_data, entB);
      nextCycle();
      #1;
      checkOutput("order_headC", out_data, entC);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0);
      #1;
      checkBit("empty_out_valid", out_valid, 1'b0);
      checkOutput("empty_out_data", out_data, '0);

      // ALU wakeup of a buffered src1.
      applyStimulus(1'b1, entD, 1'b0);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0);
      alu_broadcast_valid = 1'b1; alu_broadcast_rob_id = 6'd6; alu_broadcast_reg_data = 32'hBAD;
      #1;
      checkOutput("alu_tag_mismatch", out_data, entD);
      nextCycle();
      alu_broadcast_rob_id = 6'd5; alu_broadcast_reg_data = 32'hDEAD;
      #1;
      checkOutput("alu_merge_comb", out_data,
                  mk(16'h0D00, 6'd4, 1'b1, 1'b1, 6'd5, 32'hDEAD, 1'b1, 1'b1, 6'd12, 32'h22));
      nextCycle();
      clearSnoop();
      applyStimulus(1'b0, '0, 1'b1);
      #1;
      checkOutput("alu_stored", out_data,
                  mk(16'h0D00, 6'd4, 1'b1, 1'b1, 6'd5, 32'hDEAD, 1'b1, 1'b1, 6'd12, 32'h22));
      nextCycle();

      // Load broadcast in the dequeue cycle is visible on out_data.
      applyStimulus(1'b1, entE, 1'b0);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b1);
      ld_broadcast_valid = 1'b1; ld_broadcast_rob_id = 6'd7; ld_broadcast_reg_data = 32'h1234;
      #1;
      checkOutput("ld_deq_merge", out_data,
                  mk(16'h0E00, 6'd6, 1'b1, 1'b1, 6'd3, 32'h33, 1'b1, 1'b1, 6'd7, 32'h1234));
      nextCycle();
      clearSnoop();
      applyStimulus(1'b0, '0, 1'b0);
      #1;
      checkBit("ld_deq_empty", out_valid, 1'b0);

      // ALU and load on the same tag during enqueue: ALU data kept, ready src untouched.
      applyStimulus(1'b1, entF, 1'b0);
      alu_broadcast_valid = 1'b1; alu_broadcast_rob_id = 6'd9; alu_broadcast_reg_data = 32'hAAAA;
      ld_broadcast_valid  = 1'b1; ld_broadcast_rob_id  = 6'd9; ld_broadcast_reg_data  = 32'hBBBB;
      #1;
      checkBit("enqF_no_bypass", out_valid, 1'b0);
      nextCycle();
      clearSnoop();
      applyStimulus(1'b0, '0, 1'b1);
      #1;
      checkOutput("alu_over_ld", out_data,
                  mk(16'h0F00, 6'd8, 1'b1, 1'b1, 6'd9, 32'hAAAA, 1'b1, 1'b1, 6'd9, 32'h11));
      nextCycle();

      // Issue wakeup sets ready only; invalid broadcasts on the same tag are ignored.
      applyStimulus(1'b1, entG, 1'b0);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b1);
      iiq_issue_valid = 1'b1; iiq_issue_rob_id = 6'd9;
      alu_broadcast_rob_id = 6'd9; alu_broadcast_reg_data = 32'hFFFF;
      ld_broadcast_rob_id  = 6'd9; ld_broadcast_reg_data  = 32'hEEEE;
      #1;
      checkOutput("issue_wakeup", out_data,
                  mk(16'h1100, 6'd10, 1'b1, 1'b1, 6'd9, 32'h77, 1'b0, 1'b0, 6'd0, 32'h0));
      nextCycle();
      clearSnoop();

      // Flush with a full buffer and a new uop offered.
      applyStimulus(1'b1, entH, 1'b0);
      nextCycle();
      applyStimulus(1'b1, entI, 1'b0);
      nextCycle();
      applyStimulus(1'b1, entJ, 1'b0);
      fetch_redirect_valid = 1'b1;
      #1;
      checkBit("flush_cycle_out_valid", out_valid, 1'b1);
      checkBit("flush_cycle_in_ready", in_ready, 1'b0);
      checkOutput("flush_cycle_head", out_data, entH);
      nextCycle();
      fetch_redirect_valid = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      #1;
      checkBit("post_flush_out_valid", out_valid, 1'b0);
      checkBit("post_flush_in_ready", in_ready, 1'b1);

      // Flush overrides an accepted enq and a deq; pointers restart at zero.
      applyStimulus(1'b1, entK, 1'b0);
      nextCycle();
      applyStimulus(1'b1, entL, 1'b1);
      fetch_redirect_valid = 1'b1;
      #1;
      checkBit("flush2_in_ready", in_ready, 1'b1);
      nextCycle();
      fetch_redirect_valid = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      #1;
      checkBit("flush2_out_valid", out_valid, 1'b0);
      applyStimulus(1'b1, entM, 1'b0);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0);
      #1;
      checkOutput("post_flush_head", out_data, entM);

      // Asynchronous reset mid-operation.
      #2;
      rst_aL = 1'b0;
      #1;
      checkBit("async_reset_out_valid", out_valid, 1'b0);
      checkBit("async_reset_in_ready", in_ready, 1'b1);
      checkOutput("async_reset_out_data", out_data, '0);
      @(negedge clk);
      rst_aL = 1'b1;
      nextCycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
